// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the
// shared 4-bit ALU and its two-requester arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Shared 4-bit combinational ALU; every result is
// truncated to 4 bits (shifts by 4 or more give zero).
module alu
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] op_i,
    output logic [3:0] y_o
);

    // Opcode decode into a 4-bit result.
    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_SHL:  y_o = a_i << b_i;
            OP_SHR:  y_o = a_i >> b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters,
// with registered operands and a single tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_y,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_y_q, rsp_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       idle;
    logic       grant0;
    logic       grant1;
    logic [3:0] alu_y;

    // A lone valid wins; on contention the pointer decides.
    always_comb begin
        idle   = (state_q == IDLE);
        grant0 = req0_valid & (~req1_valid | ~prio_q);
        grant1 = req1_valid & (~req0_valid | prio_q);
    end

    assign req0_ready = rst_n & idle & grant0;
    assign req1_ready = rst_n & idle & grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_y      = rsp_y_q;
    assign busy       = ~idle;
    assign op_count   = cnt_q;

    alu u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    // Next-state: accept, execute, then hold the response.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    op_d    = grant1 ? req1_op : req0_op;
                    id_d    = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d     = alu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    prio_d      = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order,
// ALU results, back-pressure, reset mid-op, counter wrap.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [3:0] req0_a = '0;
    logic [3:0] req0_b = '0;
    logic [2:0] req0_op = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [3:0] req1_a = '0;
    logic [3:0] req1_b = '0;
    logic [2:0] req1_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [3:0] rsp_y;
    logic       busy;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int which, input int v,
                         input int a, input int b, input int op);
        if (which == 0) begin
            req0_valid = 1'(v);
            req0_a     = 4'(a);
            req0_b     = 4'(b);
            req0_op    = 3'(op);
        end else begin
            req1_valid = 1'(v);
            req1_a     = 4'(a);
            req1_b     = 4'(b);
            req1_op    = 3'(op);
        end
    endtask

    task automatic do_reset(input int both_valid);
        rst_n = 1'b0;
        drive(0, both_valid, 9, 4, 1);
        drive(1, both_valid, 6, 3, 2);
        #1;
        check("rst_r0", req0_ready, 0);
        check("rst_r1", req1_ready, 0);
        step();
        check("rst_rv", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_y", rsp_y, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", op_count, 0);
        check("rst_r0b", req0_ready, 0);
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
    endtask

    task automatic expect_rsp(input int id, input int y, input string tag);
        int i;
        i = 0;
        while (!rsp_valid && i < 8) begin
            step();
            i++;
        end
        check({tag, "_rv"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_y"}, rsp_y, y);
    endtask

    // From IDLE with rsp_ready high: issue, check latency, consume.
    task automatic run_op(input int which, input int a, input int b,
                          input int op, input int y, input string tag);
        int i;
        drive(which, 1, a, b, op);
        #1;
        i = 0;
        while (((which == 0) ? req0_ready : req1_ready) == 1'b0 && i < 4) begin
            step();
            i++;
        end
        check({tag, "_rdy"}, (which == 0) ? req0_ready : req1_ready, 1);
        step();
        drive(which, 0, a, b, op);
        check({tag, "_exec"}, rsp_valid, 0);
        check({tag, "_busy"}, busy, 1);
        step();
        check({tag, "_lat"}, rsp_valid, 1);
        expect_rsp(which, y, tag);
        step();
        exp_cnt++;
        check({tag, "_cnt"}, op_count, exp_cnt % 256);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset(0);

        run_op(0, 5, 3, 0, 8, "add");

        do_reset(1);
        check("c1_r0", req0_ready, 1);
        check("c1_r1", req1_ready, 0);
        step();
        drive(0, 0, 9, 4, 1);
        check("c1_busy", busy, 1);
        check("c1_xr1", req1_ready, 0);
        step();
        expect_rsp(0, 5, "c1");
        step();
        exp_cnt++;
        check("c1_cnt", op_count, exp_cnt);
        drive(0, 1, 9, 4, 1);
        #1;
        check("c2_r1", req1_ready, 1);
        check("c2_r0", req0_ready, 0);
        step();
        step();
        expect_rsp(1, 5, "c2");
        step();
        exp_cnt++;
        check("c3_r0", req0_ready, 1);
        check("c3_r1", req1_ready, 0);
        step();
        drive(0, 0, 9, 4, 1);
        step();
        expect_rsp(0, 5, "c3");
        step();
        exp_cnt++;
        check("c4_r1", req1_ready, 1);
        check("c4_r0", req0_ready, 0);
        step();
        drive(1, 0, 6, 3, 2);
        step();
        expect_rsp(1, 5, "c4");
        step();
        exp_cnt++;
        check("c4_cnt", op_count, exp_cnt);

        run_op(0, 15, 1, 0, 0, "addw");
        run_op(1, 2, 5, 1, 13, "subw");
        run_op(0, 3, 2, 6, 12, "shl");
        run_op(1, 12, 4, 7, 0, "shr4");
        run_op(0, 5, 3, 5, 9, "xnor");
        run_op(1, 9, 4, 4, 13, "or");
        run_op(0, 12, 10, 3, 8, "and");

        rsp_ready = 1'b0;
        drive(1, 1, 7, 7, 3);
        #1;
        check("bp_rdy", req1_ready, 1);
        step();
        drive(1, 0, 7, 7, 3);
        drive(0, 1, 1, 1, 0);
        step();
        expect_rsp(1, 7, "bp");
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_rv", rsp_valid, 1);
            check("bp_y", rsp_y, 7);
            check("bp_id", rsp_id, 1);
            check("bp_busy", busy, 1);
            check("bp_r0", req0_ready, 0);
            check("bp_r1", req1_ready, 0);
            check("bp_cnt", op_count, exp_cnt);
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt++;
        check("bp_cnt2", op_count, exp_cnt);
        check("bp_rv0", rsp_valid, 0);
        check("bp_idle", busy, 0);
        check("bp_r0n", req0_ready, 1);
        step();
        drive(0, 0, 1, 1, 0);
        step();
        expect_rsp(0, 2, "bp2");
        step();
        exp_cnt++;
        check("bp2_cnt", op_count, exp_cnt);

        drive(0, 1, 1, 2, 0);
        #1;
        check("mr_rdy", req0_ready, 1);
        step();
        drive(0, 0, 1, 2, 0);
        check("mr_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mr_rv", rsp_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_cnt", op_count, 0);
        check("mr_y", rsp_y, 0);
        check("mr_id", rsp_id, 0);
        drive(0, 1, 1, 2, 0);
        drive(1, 1, 1, 2, 0);
        #1;
        check("mr_r0", req0_ready, 0);
        check("mr_r1", req1_ready, 0);
        step();
        check("mr_rv2", rsp_valid, 0);
        step();
        check("mr_rv3", rsp_valid, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        exp_cnt = 0;
        step();
        check("mr_rv4", rsp_valid, 0);
        run_op(1, 1, 2, 0, 3, "post");

        for (int k = 0; k < 255; k++) begin
            run_op(k % 2, k % 16, 1, 0, (k + 1) % 16, "loop");
        end
        check("wrap_cnt", op_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
